// File: rtl/dac_sample_fifo_if.sv
// ------------------------------------------------------------------
// dac_sample_fifo_if: producer handshake, frame strobe and DAC-side outputs
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

interface dac_sample_fifo_if #(
  parameter int DAC_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DAC_WIDTH-1:0]  in_left;
  logic [DAC_WIDTH-1:0]  in_right;
  logic                  frame_strobe;
  logic [DAC_WIDTH-1:0]  left;
  logic [DAC_WIDTH-1:0]  right;
  logic [DEPTH_LOG2:0]   level;
  logic [15:0]           underrun_cnt;
  logic                  running;

  modport master (
    output in_valid, in_left, in_right, frame_strobe,
    input  in_ready, left, right, level, underrun_cnt, running
  );

  modport slave (
    input  in_valid, in_left, in_right, frame_strobe,
    output in_ready, left, right, level, underrun_cnt, running
  );
endinterface

`default_nettype wire

// File: rtl/dac_sample_fifo.sv
// ------------------------------------------------------------------
// dac_sample_fifo: stereo PCM FIFO, signed->offset binary, one pair per DAC frame
// Option macro: DAC_SAMPLE_FIFO_MUTE_ON_UNDERRUN_EN.  Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module dac_sample_fifo #(
  parameter int DAC_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter int PREFILL    = 4
) (
  input  wire logic          clk,
  input  wire logic          arst,
  dac_sample_fifo_if.slave   bus
);

  localparam int unsigned         c_depth    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full     = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [DEPTH_LOG2:0] c_prefill  = (DEPTH_LOG2 + 1)'(PREFILL);
  localparam logic [DAC_WIDTH-1:0] c_midscale = {1'b1, {(DAC_WIDTH - 1){1'b0}}};

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [DAC_WIDTH-1:0]    left_q, left_d;
  logic [DAC_WIDTH-1:0]    right_q, right_d;
  logic [15:0]             ucnt_q, ucnt_d;
  logic                    strobe_q;
  logic [2*DAC_WIDTH-1:0]  mem_q [c_depth];

  logic                    w_wr_en;
  logic                    w_rd_en;
  logic                    w_pop_evt;
  logic [2*DAC_WIDTH-1:0]  w_head;

  assign bus.in_ready     = !arst && (level_q != c_full);
  assign w_wr_en          = bus.in_valid && bus.in_ready;
  assign w_pop_evt        = bus.frame_strobe && !strobe_q;
  assign w_head           = mem_q[rd_ptr_q];

  assign bus.left         = left_q;
  assign bus.right        = right_q;
  assign bus.level        = level_q;
  assign bus.underrun_cnt = ucnt_q;
  assign bus.running      = (state_q == ST_RUN);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    left_d   = left_q;
    right_d  = right_q;
    ucnt_d   = ucnt_q;
    w_rd_en  = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (level_q >= c_prefill) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_pop_evt) begin
          if (level_q != '0) begin
            w_rd_en = 1'b1;
            // Offset binary is the two's-complement word with its MSB flipped.
            left_d  = w_head[2*DAC_WIDTH-1 -: DAC_WIDTH] ^ c_midscale;
            right_d = w_head[DAC_WIDTH-1:0] ^ c_midscale;
          end else begin
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            state_d = ST_FILL;
`ifdef DAC_SAMPLE_FIFO_MUTE_ON_UNDERRUN_EN
            left_d  = c_midscale;
            right_d = c_midscale;
`else
            left_d  = left_q;
            right_d = right_q;
`endif
          end
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (w_wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({w_wr_en, w_rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= ST_FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      left_q   <= c_midscale;
      right_q  <= c_midscale;
      ucnt_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      left_q   <= left_d;
      right_q  <= right_d;
      ucnt_q   <= ucnt_d;
      strobe_q <= bus.frame_strobe;
    end
  end

  // Storage needs no reset; level and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= {bus.in_left, bus.in_right};
  end

endmodule

`default_nettype wire
